prime_trial_ctrl: RTL

Sequencer for the trial-division primality datapath behind the user-facing selector/LED front end. On start it takes a candidate n and walks divisors d = 2, 3, … while d*d <= n. For each divisor it issues one remainder request to a shared remainder unit over a valid/ready handshake and consumes the response. It reports prime/composite, the smallest factor found and the number of requests issued.

---
 rtl/prime_trial_ctrl.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/prime_trial_ctrl.sv
// Trial-division primality sequencer: walks divisors d while d*d <= n through a shared remainder unit.
// Optional macro PRIME_SKIP_EVEN_EN: resolve even n>2 without a request and test odd divisors only.
//
// state | meaning
// IDLE  | no check in progress, waiting for start
// ISSUE | decide termination or hold a remainder request until accepted
// WAIT  | request accepted, waiting for its remainder
// DRAIN | aborted while a response is outstanding; swallow it
// DONE  | result final and held, waiting for start
module prime_trial_ctrl #(
  parameter int WIDTH  = 8,
  parameter int ITER_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic              abort_i,
  input  logic [WIDTH-1:0]  n_i,
  output logic              req_valid_o,
  input  logic              req_ready_i,
  output logic [WIDTH-1:0]  req_dividend_o,
  output logic [WIDTH-1:0]  req_divisor_o,
  input  logic              rsp_valid_i,
  input  logic [WIDTH-1:0]  rsp_rem_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              prime_o,
  output logic [WIDTH-1:0]  factor_o,
  output logic [ITER_W-1:0] iter_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_DRAIN,
    S_DONE
  } state_t;

`ifdef PRIME_SKIP_EVEN_EN
  localparam bit SKIP_EVEN = 1'b1;
  localparam logic [WIDTH-1:0] D_FIRST = WIDTH'(3);
  localparam logic [WIDTH:0]   D_STEP  = (WIDTH+1)'(2);
`else
  localparam bit SKIP_EVEN = 1'b0;
  localparam logic [WIDTH-1:0] D_FIRST = WIDTH'(2);
  localparam logic [WIDTH:0]   D_STEP  = (WIDTH+1)'(1);
`endif
  localparam logic [WIDTH-1:0] D_RESET = WIDTH'(2);

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   n_q, n_d;
  logic [WIDTH-1:0]   d_q, d_d;
  logic [ITER_W-1:0]  iter_q, iter_d;
  logic [WIDTH-1:0]   factor_q, factor_d;
  logic               prime_q, prime_d;
  logic               done_q, done_d;
  logic               req_valid_q, req_valid_d;
  logic               busy_q, busy_d;
  logic [WIDTH:0]     d_next;

  function automatic logic even_comp(input logic [WIDTH-1:0] n);
    return SKIP_EVEN && !n[0] && (n > WIDTH'(2));
  endfunction

  // Square computed in double width so d*d never overflows.
  function automatic logic need_req(input logic [WIDTH-1:0] n, input logic [WIDTH-1:0] d);
    logic [2*WIDTH-1:0] sq;
    sq = (2*WIDTH)'(d) * (2*WIDTH)'(d);
    return (n >= WIDTH'(2)) && !even_comp(n) && (sq <= (2*WIDTH)'(n));
  endfunction

  assign d_next = {1'b0, d_q} + D_STEP;

  always_comb begin
    state_d  = state_q;
    n_d      = n_q;
    d_d      = d_q;
    iter_d   = iter_q;
    prime_d  = prime_q;
    factor_d = factor_q;
    done_d   = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start_i) begin
          state_d  = S_ISSUE;
          n_d      = n_i;
          d_d      = D_FIRST;
          iter_d   = '0;
          prime_d  = 1'b0;
          factor_d = '0;
        end
      end
      S_ISSUE: begin
        if (abort_i) begin
          state_d = S_IDLE;
        end else if (req_valid_q) begin
          if (req_ready_i) begin
            state_d = S_WAIT;
            if (iter_q != '1) iter_d = iter_q + ITER_W'(1);
          end
        end else begin
          state_d = S_DONE;
          done_d  = 1'b1;
          if (n_q < WIDTH'(2)) begin
            prime_d = 1'b0;
          end else if (even_comp(n_q)) begin
            prime_d  = 1'b0;
            factor_d = WIDTH'(2);
          end else begin
            prime_d = 1'b1;
          end
        end
      end
      S_WAIT: begin
        // A response coinciding with the abort is the outstanding one, so no drain is needed.
        if (abort_i) begin
          state_d = rsp_valid_i ? S_IDLE : S_DRAIN;
        end else if (rsp_valid_i) begin
          if (rsp_rem_i == '0) begin
            state_d  = S_DONE;
            done_d   = 1'b1;
            prime_d  = 1'b0;
            factor_d = d_q;
          end else if (d_next[WIDTH]) begin
            state_d = S_DONE;
            done_d  = 1'b1;
            prime_d = 1'b1;
          end else begin
            state_d = S_ISSUE;
            d_d     = d_next[WIDTH-1:0];
          end
        end
      end
      S_DRAIN: begin
        if (rsp_valid_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    req_valid_d = (state_d == S_ISSUE) && need_req(n_d, d_d);
    busy_d      = (state_d == S_ISSUE) || (state_d == S_WAIT) || (state_d == S_DRAIN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      n_q         <= '0;
      d_q         <= D_RESET;
      iter_q      <= '0;
      prime_q     <= 1'b0;
      factor_q    <= '0;
      done_q      <= 1'b0;
      req_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      n_q         <= n_d;
      d_q         <= d_d;
      iter_q      <= iter_d;
      prime_q     <= prime_d;
      factor_q    <= factor_d;
      done_q      <= done_d;
      req_valid_q <= req_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign req_valid_o    = req_valid_q;
  assign req_dividend_o = n_q;
  assign req_divisor_o  = d_q;
  assign busy_o         = busy_q;
  assign done_o         = done_q;
  assign prime_o        = prime_q;
  assign factor_o       = factor_q;
  assign iter_o         = iter_q;

endmodule
